// File: rtl/tt_um_johnson_rx.sv
// tt_um_johnson_rx: receive-side checker for an 8-bit Johnson counter stream.
// Stage 1 captures a strobed code word; stage 2 decodes it to a phase,
// flags illegal codes and runs a flywheel lock FSM with a saturating
// error counter.
//
// Handshake: there is no valid/ready pair. uio_in[0] is a one-cycle
// "valid" strobe that is always accepted when ena=1 (no backpressure);
// each accepted strobe produces exactly one stage-2 update on the next edge.
module tt_um_johnson_rx #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_VAL = GW'(LOCK_COUNT);

  // Stage 1 registers
  logic [7:0]       code_q, code_d;
  logic             sample_v_q, sample_v_d;

  // Stage 2 registers
  logic [3:0]       phase_q, phase_d;
  logic             legal_q, legal_d;
  state_t           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic             miss_q, miss_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Decode helpers
  logic [2:0]       trans;
  logic [3:0]       pop;
  logic             dec_legal;
  logic [3:0]       dec_phase;
  logic             dec_good;
  logic [GW-1:0]    good_inc;
  logic             err_inc;

  logic unused_uio_bits;
  assign unused_uio_bits = ^uio_in[7:2];

  // Decode the captured word: legality by adjacent-bit transitions, phase by popcount.
  always_comb begin
    trans = 3'd0;
    pop   = 4'd0;
    for (int i = 0; i < 7; i++) begin
      trans = trans + {2'b00, code_q[i] ^ code_q[i+1]};
    end
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'b000, code_q[i]};
    end
    dec_legal = (trans <= 3'd1);
    // 16 - popcount wraps to -popcount in 4 bits; MSB-set codes are the falling half.
    dec_phase = code_q[7] ? (4'd0 - pop) : pop;
    dec_good  = dec_legal && (dec_phase == expected_q);
    good_inc  = good_cnt_q + GW'(1);
  end

  // Stage 1: capture a strobed word while enabled.
  always_comb begin
    code_d     = code_q;
    sample_v_d = 1'b0;
    if (ena && uio_in[0]) begin
      code_d     = ui_in;
      sample_v_d = 1'b1;
    end
  end

  // Stage 2: phase/legal registers and lock FSM next state.
  always_comb begin
    phase_d    = phase_q;
    legal_d    = legal_q;
    state_d    = state_q;
    expected_d = expected_q;
    good_cnt_d = good_cnt_q;
    miss_d     = miss_q;
    seq_err_d  = 1'b0;
    err_inc    = 1'b0;
    if (sample_v_q) begin
      legal_d = dec_legal;
      if (dec_legal) phase_d = dec_phase;
      case (state_q)
        ST_HUNT: begin
          if (dec_legal) begin
            expected_d = dec_phase + 4'd1;
            good_cnt_d = '0;
            state_d    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (dec_good) begin
            good_cnt_d = good_inc;
            expected_d = expected_q + 4'd1;
            if (good_inc == LOCK_VAL) begin
              state_d = ST_LOCKED;
              miss_d  = 1'b0;
            end
          end else if (dec_legal) begin
            expected_d = dec_phase + 4'd1;
            good_cnt_d = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: expected advances on every sample, good or bad.
          expected_d = expected_q + 4'd1;
          if (dec_good) begin
            miss_d = 1'b0;
          end else begin
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
            miss_d    = 1'b1;
            if (miss_q) begin
              state_d = ST_HUNT;
              miss_d  = 1'b0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Error counter: clear beats increment, increment saturates.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ena && uio_in[1]) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // All state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= 8'h00;
      sample_v_q <= 1'b0;
      phase_q    <= 4'd0;
      legal_q    <= 1'b0;
      state_q    <= ST_HUNT;
      expected_q <= 4'd0;
      good_cnt_q <= '0;
      miss_q     <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      code_q     <= code_d;
      sample_v_q <= sample_v_d;
      phase_q    <= phase_d;
      legal_q    <= legal_d;
      state_q    <= state_d;
      expected_q <= expected_d;
      good_cnt_q <= good_cnt_d;
      miss_q     <= miss_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign uo_out  = {(err_cnt_q == {ERR_W{1'b1}}), seq_err_q,
                    (state_q == ST_LOCKED), legal_q, phase_q};
  assign uio_out = {err_cnt_q, 2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_tt_um_johnson_rx.sv
// Bench for tt_um_johnson_rx: directed and random strobes checked against a
// table-driven reference model of the receiver.
module tb_tt_um_johnson_rx;

  localparam int LOCK_COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors;
  int miscompares;

  // Reference model state
  logic [7:0] jc [16];
  int  m_phase, m_exp, m_good, m_miss, m_cnt, m_mode;
  bit  m_legal, m_seq_err;
  bit  pend_v;
  logic [7:0] pend_code;
  int  tx_idx;
  logic [7:0] last_code;

  localparam int HUNT = 0, CHECK = 1, LOCKED = 2;

  tt_um_johnson_rx #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of a code in the Johnson sequence, -1 if not a member.
  function automatic int phase_of(input logic [7:0] c);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (jc[i] == c) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_exp = 0; m_good = 0; m_miss = 0; m_cnt = 0;
    m_mode = HUNT; m_legal = 0; m_seq_err = 0; pend_v = 0; pend_code = 8'h00;
  endtask

  // One rising edge of the reference receiver.
  task automatic model_edge();
    int idx;
    bit good, inc;
    m_seq_err = 0;
    inc = 0;
    if (pend_v) begin
      idx = phase_of(pend_code);
      m_legal = (idx >= 0);
      if (idx >= 0) m_phase = idx;
      good = (idx >= 0) && (idx == m_exp);
      if (m_mode == HUNT) begin
        if (idx >= 0) begin m_exp = (idx + 1) % 16; m_good = 0; m_mode = CHECK; end
      end else if (m_mode == CHECK) begin
        if (good) begin
          m_good++;
          m_exp = (m_exp + 1) % 16;
          if (m_good == LOCK_COUNT) begin m_mode = LOCKED; m_miss = 0; end
        end else if (idx >= 0) begin
          m_exp = (idx + 1) % 16; m_good = 0;
        end else begin
          m_mode = HUNT;
        end
      end else begin
        m_exp = (m_exp + 1) % 16;
        if (good) m_miss = 0;
        else begin
          m_seq_err = 1; inc = 1; m_miss++;
          if (m_miss == 2) begin m_mode = HUNT; m_miss = 0; end
        end
      end
    end
    if (ena && uio_in[1]) m_cnt = 0;
    else if (inc && m_cnt < 63) m_cnt++;
    pend_v = ena && uio_in[0];
    if (pend_v) pend_code = ui_in;
  endtask

  task automatic check(input string tag);
    logic [7:0] exp_uo, exp_uio;
    exp_uo  = {(m_cnt == 63), m_seq_err, (m_mode == LOCKED), m_legal, 4'(m_phase)};
    exp_uio = {6'(m_cnt), 2'b00};
    vectors++;
    assert (uo_out === exp_uo) else begin
      miscompares++;
      $error("FAIL %s uo_out got %h want %h", tag, uo_out, exp_uo);
    end
    vectors++;
    assert (uio_out === exp_uio) else begin
      miscompares++;
      $error("FAIL %s uio_out got %h want %h", tag, uio_out, exp_uio);
    end
    vectors++;
    assert (uio_oe === 8'hFC) else begin
      miscompares++;
      $error("FAIL %s uio_oe got %h want fc", tag, uio_oe);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check after it.
  task automatic step(input bit e, input bit s, input bit c, input logic [7:0] code,
                      input string tag);
    @(negedge clk);
    ena    = e;
    ui_in  = code;
    uio_in = {6'($urandom), c, s};
    if (s) last_code = code;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check(tag);
  endtask

  task automatic send_next(input string tag);
    step(1, 1, 0, jc[tx_idx % 16], tag);
    tx_idx++;
  endtask

  initial begin
    logic [7:0] c;
    vectors = 0; miscompares = 0; tx_idx = 0; last_code = 8'h00;
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      jc[i] = c;
      c = {c[6:0], ~c[7]};
    end

    // Reset and idle
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    #1;
    check("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom), "idle");

    // Acquire lock from 00 upwards
    tx_idx = 0;
    for (int i = 0; i < 6; i++) send_next("acquire");
    step(1, 0, 0, 8'h00, "acquire_flush");

    // Run through FE ... 80 and wrap to 00
    for (int i = 0; i < 12; i++) send_next("wrap");
    step(1, 0, 0, 8'h00, "wrap_flush");

    // Single illegal sample while locked, then correct flywheel successor
    step(1, 1, 0, 8'h05, "illegal_inj");
    tx_idx++;
    send_next("recover");
    send_next("recover2");
    step(1, 0, 0, 8'h00, "recover_flush");

    // Two consecutive bad samples drop lock
    step(1, 1, 0, 8'h55, "bad1");
    step(1, 1, 0, 8'hAA, "bad2");
    step(1, 0, 0, 8'h00, "unlock_flush");

    // Drive the error counter into saturation
    for (int n = 0; n < 35; n++) begin
      for (int i = 0; i < 5; i++) send_next("sat_lock");
      step(1, 1, 0, 8'h55, "sat_bad1");
      step(1, 1, 0, 8'h55, "sat_bad2");
    end
    step(1, 0, 0, 8'h00, "sat_flush");

    // Clear coinciding with an error increment
    for (int i = 0; i < 5; i++) send_next("clr_lock");
    step(1, 1, 0, 8'h55, "clr_bad");
    step(1, 0, 1, 8'h00, "clr_win");
    step(1, 0, 0, 8'h00, "clr_after");

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] code;
      bit e, s, cl;
      e  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 31) == 0);
      r  = $urandom_range(0, 9);
      if (r < 7) begin code = jc[tx_idx % 16]; if (s) tx_idx++; end
      else if (r == 7) code = jc[$urandom_range(0, 15)];
      else if (r == 8) code = 8'($urandom);
      else code = last_code;
      step(e, s, cl, code, "random");
    end

    // Asynchronous reset mid-stream with ena toggling
    for (int i = 0; i < 6; i++) send_next("pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    for (int i = 0; i < 4; i++) step(i % 2 == 0, 1, 1, jc[i], "in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 0, jc[i], "ena_low");
    for (int i = 0; i < 6; i++) send_next("post_rst");
    step(1, 0, 0, 8'h00, "post_flush");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
